// File: rtl/tone_pkg.sv
// Shared types and constants for the tone period meter and its frequency divider.
package tone_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

    localparam int DIV_WIDTH   = 32;
    // One load cycle plus one cycle per quotient bit.
    localparam int DIV_LATENCY = 33;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider producing one quotient bit per cycle; start/busy/done handshake.
module serial_divider
    import tone_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [DIV_WIDTH-1:0] quotient
);

    localparam int STEPS   = DIV_LATENCY - 1;
    localparam int STEP_W  = $clog2(STEPS + 1);

    logic [DIV_WIDTH-1:0] dvd_q;
    logic [DIV_WIDTH-1:0] dsr_q;
    logic [DIV_WIDTH-1:0] rem_q;
    logic [STEP_W-1:0]    step_q;

    logic [DIV_WIDTH:0]   rem_shift;
    logic [DIV_WIDTH:0]   diff;
    logic                 q_bit;
    logic [DIV_WIDTH-1:0] rem_next;
    logic [DIV_WIDTH-1:0] quo_next;

    // The dividend register doubles as the quotient shift register: each step
    // shifts one dividend bit out into the remainder and one quotient bit in.
    always_comb begin
        rem_shift = {rem_q, dvd_q[DIV_WIDTH-1]};
        diff      = rem_shift - {1'b0, dsr_q};
        q_bit     = ~diff[DIV_WIDTH];
        rem_next  = q_bit ? diff[DIV_WIDTH-1:0] : rem_shift[DIV_WIDTH-1:0];
        quo_next  = {dvd_q[DIV_WIDTH-2:0], q_bit};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            step_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                dvd_q  <= dividend;
                dsr_q  <= divisor;
                rem_q  <= '0;
                step_q <= STEP_W'(STEPS);
                busy   <= 1'b1;
            end else if (busy) begin
                dvd_q  <= quo_next;
                rem_q  <= rem_next;
                step_q <= step_q - 1'b1;
                if (step_q == STEP_W'(1)) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    quotient <= quo_next;
                end
            end
        end
    end

endmodule

// File: rtl/tone_period_meter.sv
// Measures rising-edge-to-rising-edge period of an asynchronous square wave.
// Define TONE_FREQ_DIV_EN to also produce frequency x100 via serial_divider.
module tone_period_meter
    import tone_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 12000000,
    parameter int          PERIOD_WIDTH    = 24,
    parameter int          MIN_PERIOD      = 64,
    parameter int          TIMEOUT_CYCLES  = 1000000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    tone_in,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid,
    output logic                    no_signal,
    output logic [DIV_WIDTH-1:0]    freq_mul_100,
    output logic                    freq_valid
);

    localparam logic [PERIOD_WIDTH-1:0] MIN_CNT     = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] TIMEOUT_CNT = PERIOD_WIDTH'(TIMEOUT_CYCLES);

    if (64'(CLOCK_FREQUENCY) * 64'd100 >= (64'd1 << DIV_WIDTH)) begin : g_bad_clock
        $error("CLOCK_FREQUENCY*100 does not fit the divider width");
    end
    if (64'(TIMEOUT_CYCLES) >= (64'd1 << PERIOD_WIDTH)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be below 2**PERIOD_WIDTH");
    end

    logic [2:0]              sync_q;
    logic                    rise;
    meter_state_t            state_q, state_d;
    logic [PERIOD_WIDTH-1:0] cnt_q;
    logic                    accept;
    logic                    timeout;

    always_ff @(posedge clock) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[1:0], tone_in};
    end

    assign rise = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) state_d = MEASURE;
            end
            MEASURE: begin
                // Timeout wins over a coincident rise.
                if (cnt_q == TIMEOUT_CNT) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else if (rise && cnt_q >= MIN_CNT) begin
                    accept = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            no_signal    <= 1'b1;
        end else begin
            period_valid <= accept;
            if (state_q == IDLE) begin
                if (rise) cnt_q <= PERIOD_WIDTH'(1);
            end else if (timeout) begin
                cnt_q     <= '0;
                period    <= '0;
                no_signal <= 1'b1;
            end else if (accept) begin
                cnt_q     <= PERIOD_WIDTH'(1);
                period    <= cnt_q;
                no_signal <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef TONE_FREQ_DIV_EN
    if (MIN_PERIOD < 40) begin : g_bad_min_period
        $error("MIN_PERIOD must be at least 40 so the divider is always idle");
    end

    localparam logic [DIV_WIDTH-1:0] FREQ_DIVIDEND = DIV_WIDTH'(64'(CLOCK_FREQUENCY) * 64'd100);

    logic div_busy;

    serial_divider u_divider (
        .clock    (clock),
        .reset    (reset),
        .start    (period_valid & ~div_busy),
        .dividend (FREQ_DIVIDEND),
        .divisor  (DIV_WIDTH'(period)),
        .busy     (div_busy),
        .done     (freq_valid),
        .quotient (freq_mul_100)
    );
`else
    assign freq_mul_100 = '0;
    assign freq_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_tone_period_meter.sv
// Scoreboard bench for tone_period_meter: expected periods/frequencies queued at each driven rise.
module tb_tone_period_meter;

    localparam int unsigned CLK_HZ  = 1_200_000;
    localparam int          PW      = 16;
    localparam int          MINP    = 64;
    localparam int          TMO     = 8000;
    localparam int          DIV_LAT = 33;

    logic          clock = 1'b0;
    logic          reset;
    logic          tone_in;
    logic [PW-1:0] period;
    logic          period_valid;
    logic          no_signal;
    logic [31:0]   freq_mul_100;
    logic          freq_valid;

    tone_period_meter #(
        .CLOCK_FREQUENCY (CLK_HZ),
        .PERIOD_WIDTH    (PW),
        .MIN_PERIOD      (MINP),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tone_in      (tone_in),
        .period       (period),
        .period_valid (period_valid),
        .no_signal    (no_signal),
        .freq_mul_100 (freq_mul_100),
        .freq_valid   (freq_valid)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int     tests_run    = 0;
    int     tests_failed = 0;
    int     period_q[$];
    longint freq_q[$];
    int     prev_gap     = 0;
    bit     ref_valid    = 1'b0;
    int     last_pv_cyc  = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint freq_of(input int p);
        return (longint'(CLK_HZ) * 100) / p;
    endfunction

    // Queue the gap closed by this rise, if a reference rise exists.
    task automatic note_rise(input int gap);
        if (ref_valid) begin
            period_q.push_back(prev_gap);
`ifdef TONE_FREQ_DIV_EN
            freq_q.push_back(freq_of(prev_gap));
`endif
        end
        ref_valid = 1'b1;
        prev_gap  = gap;
    endtask

    task automatic tone_period(input int high, input int low);
        note_rise(high + low);
        tone_in = 1'b1;
        repeat (high) @(negedge clock);
        tone_in = 1'b0;
        repeat (low) @(negedge clock);
    endtask

    // 1000-cycle period carrying a 10-cycle glitch pulse 20 cycles after the rise.
    task automatic glitch_period();
        note_rise(1000);
        tone_in = 1'b1; repeat (10) @(negedge clock);
        tone_in = 1'b0; repeat (10) @(negedge clock);
        tone_in = 1'b1; repeat (10) @(negedge clock);
        tone_in = 1'b0; repeat (970) @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_period"},       period,       0);
        check({phase, "_period_valid"}, period_valid, 0);
        check({phase, "_no_signal"},    no_signal,    1);
        check({phase, "_freq"},         freq_mul_100, 0);
        check({phase, "_freq_valid"},   freq_valid,   0);
    endtask

    always @(negedge clock) begin
        if (!reset && period_valid) begin
            last_pv_cyc = cyc;
            check("no_signal_at_pv", no_signal, 0);
            if (period_q.size() == 0) check("pv_unexpected", 1, 0);
            else                      check("period", period, period_q.pop_front());
        end
    end

    always @(negedge clock) begin
        if (!reset && freq_valid) begin
            check("freq_latency", cyc - last_pv_cyc, DIV_LAT);
            if (freq_q.size() == 0) check("fv_unexpected", 1, 0);
            else                    check("freq_mul_100", freq_mul_100, freq_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        tone_in = 1'b0;
        reset   = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Steady tone, then a switch to half the period.
        repeat (3) tone_period(2294, 2293);
        repeat (3) tone_period(1147, 1146);

        // Glitches shorter than MIN_PERIOD must not disturb a 1000-cycle period.
        repeat (3) glitch_period();

        // Tone stops: loss of signal exactly TIMEOUT cycles after the last accepted rise.
        check("no_signal_before_timeout", no_signal, 0);
        n = 0;
        while (!no_signal && n < TMO + 100) begin
            @(negedge clock);
            n++;
        end
        check("timeout_delay", cyc - last_pv_cyc, TMO);
        check("timeout_period", period, 0);
        check("timeout_pv", period_valid, 0);
        ref_valid = 1'b0;

        // Restart: the first rise after idle yields no period.
        tone_period(500, 500);
        check("restart_no_signal", no_signal, 1);
        check("restart_period", period, 0);
        tone_period(500, 500);
        check("restart_no_signal_after", no_signal, 0);

        // Reset 10 cycles after a period_valid aborts any division.
        note_rise(1000);
        tone_in = 1'b1;
        n = 0;
        while (!period_valid && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("pv_seen_before_reset", period_valid, 1);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        period_q.delete();
        freq_q.delete();
        check_reset_outputs("midreset");
        tone_in = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (60) @(negedge clock);
        check_reset_outputs("after_reset");

        check("period_queue_drained", period_q.size(), 0);
        check("freq_queue_drained", freq_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
